// File: rtl/microwave_controller_if.sv
// Signal bundle between the microwave controller and its panel/timer.
// POWER_LEVEL_EN adds the power_sel input.
interface microwave_controller_if;
  logic       tick_1hz;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_add_min;
  logic       btn_add_sec;
  logic       door_open;
  logic       tmr_end;
  logic       tmr_load;
  logic       tmr_run;
  logic [5:0] tmr_min;
  logic [5:0] tmr_sec;
  logic       magnetron;
  logic       lamp;
  logic       beep;
  logic [2:0] state;
`ifdef POWER_LEVEL_EN
  logic [1:0] power_sel;
`endif

  modport master (
    input  tick_1hz, btn_start, btn_stop, btn_add_min, btn_add_sec, door_open, tmr_end,
`ifdef POWER_LEVEL_EN
    input  power_sel,
`endif
    output tmr_load, tmr_run, tmr_min, tmr_sec, magnetron, lamp, beep, state
  );

  modport slave (
    output tick_1hz, btn_start, btn_stop, btn_add_min, btn_add_sec, door_open, tmr_end,
`ifdef POWER_LEVEL_EN
    output power_sel,
`endif
    input  tmr_load, tmr_run, tmr_min, tmr_sec, magnetron, lamp, beep, state
  );
endinterface

// File: rtl/microwave_controller.sv
// Microwave oven sequencing FSM with registered outputs.
// Optional POWER_LEVEL_EN: magnetron duty cycle over a 4-tick window.
//   state | meaning
//   IDLE  | preset 0:00, waiting for time entry
//   SET   | preset being edited, waiting for start
//   COOK  | timer running, heating
//   PAUSE | door opened or stop pressed while cooking
//   DONE  | timer expired, beeping for 3 ticks
module microwave_controller (
  input logic                     clk,
  input logic                     rst_n,
  microwave_controller_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [1:0] beep_cnt_q, beep_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic       load_q, load_d, run_q, run_d, mag_q, mag_d, lamp_q, lamp_d, beep_q, beep_d;
  logic       preset_zero;

  assign preset_zero = (min_q == 6'd0) && (sec_q == 6'd0);

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    beep_cnt_d = beep_cnt_q;
    phase_d    = phase_q;
    load_d     = 1'b0;
    case (state_q)
      IDLE, SET: begin
        if (state_q == SET && bus.btn_stop) begin
          min_d   = 6'd0;
          sec_d   = 6'd0;
          state_d = IDLE;
        end else if (state_q == SET && bus.btn_start && !bus.door_open && !preset_zero) begin
          load_d  = 1'b1;
          phase_d = 2'd0;
          state_d = COOK;
        end else if (bus.btn_add_min) begin
          if (min_q != 6'd59) min_d = min_q + 6'd1;
          state_d = SET;
        end else if (bus.btn_add_sec) begin
          // At 59:59 the press is swallowed; otherwise seconds wrap with a minute carry.
          if (sec_q != 6'd59) begin
            sec_d = sec_q + 6'd1;
          end else if (min_q != 6'd59) begin
            sec_d = 6'd0;
            min_d = min_q + 6'd1;
          end
          state_d = SET;
        end
      end
      COOK: begin
        if (bus.tmr_end) begin
          beep_cnt_d = 2'd2;
          state_d    = DONE;
        end else if (bus.door_open || bus.btn_stop) begin
          state_d = PAUSE;
        end else if (bus.tick_1hz) begin
          phase_d = phase_q + 2'd1;
        end
      end
      PAUSE: begin
        if (bus.btn_stop) begin
          min_d   = 6'd0;
          sec_d   = 6'd0;
          load_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.btn_start && !bus.door_open) begin
          phase_d = 2'd0;
          state_d = COOK;
        end
      end
      DONE: begin
        // Down-counter loaded with 2; the tick seen at terminal count is the third.
        if (bus.door_open || bus.btn_stop || (bus.tick_1hz && beep_cnt_q == 2'd0)) begin
          min_d      = 6'd0;
          sec_d      = 6'd0;
          beep_cnt_d = 2'd0;
          state_d    = IDLE;
        end else if (bus.tick_1hz) begin
          beep_cnt_d = beep_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d  = (state_d == COOK);
    lamp_d = (state_d == COOK) || bus.door_open;
    beep_d = (state_d == DONE);
`ifdef POWER_LEVEL_EN
    // On-count is 4 - power_sel, so on while phase <= ~power_sel.
    mag_d  = (state_d == COOK) && (phase_d <= ~bus.power_sel);
`else
    mag_d  = (state_d == COOK);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      beep_cnt_q <= 2'd0;
      phase_q    <= 2'd0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      mag_q      <= 1'b0;
      lamp_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      beep_cnt_q <= beep_cnt_d;
      phase_q    <= phase_d;
      load_q     <= load_d;
      run_q      <= run_d;
      mag_q      <= mag_d;
      lamp_q     <= lamp_d;
      beep_q     <= beep_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.tmr_min   = min_q;
  assign bus.tmr_sec   = sec_q;
  assign bus.tmr_load  = load_q;
  assign bus.tmr_run   = run_q;
  assign bus.magnetron = mag_q;
  assign bus.lamp      = lamp_q;
  assign bus.beep      = beep_q;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed self-checking bench for microwave_controller.
// Covers the power-level pattern when built with POWER_LEVEL_EN.
module tb_microwave_controller;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  microwave_controller_if bus();

  microwave_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: pulses set before the call are seen by exactly one rising edge.
  task automatic cyc();
    @(negedge clk);
    bus.btn_start   = 1'b0;
    bus.btn_stop    = 1'b0;
    bus.btn_add_min = 1'b0;
    bus.btn_add_sec = 1'b0;
    bus.tick_1hz    = 1'b0;
    bus.tmr_end     = 1'b0;
  endtask

  task automatic add_sec(input int n);
    repeat (n) begin bus.btn_add_sec = 1'b1; cyc(); end
  endtask

  task automatic add_min(input int n);
    repeat (n) begin bus.btn_add_min = 1'b1; cyc(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if ({bus.state, bus.tmr_load, bus.tmr_run, bus.magnetron, bus.lamp, bus.beep} !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got state=%0d load=%0b run=%0b mag=%0b lamp=%0b beep=%0b, want all 0",
               bus.state, bus.tmr_load, bus.tmr_run, bus.magnetron, bus.lamp, bus.beep);
    end
    tests_run++;
    if ({bus.tmr_min, bus.tmr_sec} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_preset: got %0d:%0d, want 0:0", bus.tmr_min, bus.tmr_sec);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_set_and_cook();
    add_min(1);
    tests_run++;
    if (bus.state !== 3'd1 || bus.tmr_min !== 6'd1 || bus.tmr_sec !== 6'd0) begin
      tests_failed++;
      $display("FAIL idle_add_min: got state=%0d %0d:%0d, want 1 1:0", bus.state, bus.tmr_min, bus.tmr_sec);
    end
    add_sec(30);
    tests_run++;
    if (bus.state !== 3'd1 || bus.tmr_min !== 6'd1 || bus.tmr_sec !== 6'd30) begin
      tests_failed++;
      $display("FAIL preset_1_30: got state=%0d %0d:%0d, want 1 1:30", bus.state, bus.tmr_min, bus.tmr_sec);
    end
    bus.btn_start = 1'b1;
    cyc();
    tests_run++;
    if ({bus.tmr_load, bus.state, bus.tmr_run, bus.magnetron, bus.lamp} !== {1'b1, 3'd2, 3'b111}) begin
      tests_failed++;
      $display("FAIL start_cook: got load=%0b state=%0d run=%0b mag=%0b lamp=%0b, want 1 2 1 1 1",
               bus.tmr_load, bus.state, bus.tmr_run, bus.magnetron, bus.lamp);
    end
    cyc();
    tests_run++;
    if (bus.tmr_load !== 1'b0 || bus.state !== 3'd2) begin
      tests_failed++;
      $display("FAIL load_one_cycle: got load=%0b state=%0d, want 0 2", bus.tmr_load, bus.state);
    end
  endtask

  task automatic test_pause_resume();
    bus.door_open = 1'b1;
    cyc();
    tests_run++;
    if ({bus.state, bus.magnetron, bus.tmr_run, bus.lamp} !== {3'd3, 3'b001}) begin
      tests_failed++;
      $display("FAIL door_pause: got state=%0d mag=%0b run=%0b lamp=%0b, want 3 0 0 1",
               bus.state, bus.magnetron, bus.tmr_run, bus.lamp);
    end
    bus.btn_start = 1'b1;
    cyc();
    tests_run++;
    if (bus.state !== 3'd3 || bus.magnetron !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_start_door_open: got state=%0d mag=%0b, want 3 0", bus.state, bus.magnetron);
    end
    bus.door_open = 1'b0;
    cyc();
    tests_run++;
    if (bus.lamp !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_lamp_closed: got lamp=%0b, want 0", bus.lamp);
    end
    bus.btn_start = 1'b1;
    cyc();
    tests_run++;
    if ({bus.state, bus.tmr_load, bus.tmr_run, bus.magnetron} !== {3'd2, 3'b011}) begin
      tests_failed++;
      $display("FAIL resume_no_load: got state=%0d load=%0b run=%0b mag=%0b, want 2 0 1 1",
               bus.state, bus.tmr_load, bus.tmr_run, bus.magnetron);
    end
`ifndef POWER_LEVEL_EN
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b1;
    cyc();
    tests_run++;
    if (bus.magnetron !== 1'b1) begin
      tests_failed++;
      $display("FAIL cook_mag_steady: got mag=%0b, want 1", bus.magnetron);
    end
`endif
  endtask

  task automatic test_done();
    bus.tmr_end   = 1'b1;
    bus.door_open = 1'b1;
    cyc();
    bus.door_open = 1'b0;
    tests_run++;
    if ({bus.state, bus.beep, bus.magnetron, bus.tmr_run, bus.lamp} !== {3'd4, 4'b1001}) begin
      tests_failed++;
      $display("FAIL end_beats_door: got state=%0d beep=%0b mag=%0b run=%0b lamp=%0b, want 4 1 0 0 1",
               bus.state, bus.beep, bus.magnetron, bus.tmr_run, bus.lamp);
    end
    for (int t = 1; t <= 3; t++) begin
      repeat (3) cyc();
      tests_run++;
      if (bus.beep !== 1'b1 || bus.state !== 3'd4) begin
        tests_failed++;
        $display("FAIL beep_before_tick%0d: got beep=%0b state=%0d, want 1 4", t, bus.beep, bus.state);
      end
      bus.tick_1hz = 1'b1;
      cyc();
    end
    tests_run++;
    if ({bus.state, bus.beep, bus.tmr_min, bus.tmr_sec} !== {3'd0, 1'b0, 12'd0}) begin
      tests_failed++;
      $display("FAIL done_to_idle: got state=%0d beep=%0b %0d:%0d, want 0 0 0:0",
               bus.state, bus.beep, bus.tmr_min, bus.tmr_sec);
    end
  endtask

  task automatic test_carry_saturate();
    add_sec(59);
    tests_run++;
    if (bus.tmr_min !== 6'd0 || bus.tmr_sec !== 6'd59) begin
      tests_failed++;
      $display("FAIL preset_0_59: got %0d:%0d, want 0:59", bus.tmr_min, bus.tmr_sec);
    end
    add_sec(1);
    tests_run++;
    if (bus.tmr_min !== 6'd1 || bus.tmr_sec !== 6'd0) begin
      tests_failed++;
      $display("FAIL sec_carry: got %0d:%0d, want 1:0", bus.tmr_min, bus.tmr_sec);
    end
    add_min(60);
    tests_run++;
    if (bus.tmr_min !== 6'd59 || bus.tmr_sec !== 6'd0) begin
      tests_failed++;
      $display("FAIL min_saturate: got %0d:%0d, want 59:0", bus.tmr_min, bus.tmr_sec);
    end
    add_sec(59);
    add_sec(1);
    tests_run++;
    if (bus.tmr_min !== 6'd59 || bus.tmr_sec !== 6'd59 || bus.state !== 3'd1) begin
      tests_failed++;
      $display("FAIL max_hold: got state=%0d %0d:%0d, want 1 59:59", bus.state, bus.tmr_min, bus.tmr_sec);
    end
  endtask

  task automatic test_start_ignored();
    bus.door_open = 1'b1;
    bus.btn_start = 1'b1;
    cyc();
    bus.door_open = 1'b0;
    tests_run++;
    if (bus.state !== 3'd1 || bus.tmr_load !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_door_open: got state=%0d load=%0b, want 1 0", bus.state, bus.tmr_load);
    end
    bus.btn_stop = 1'b1;
    cyc();
    tests_run++;
    if ({bus.state, bus.tmr_min, bus.tmr_sec} !== {3'd0, 12'd0}) begin
      tests_failed++;
      $display("FAIL set_stop_clear: got state=%0d %0d:%0d, want 0 0:0", bus.state, bus.tmr_min, bus.tmr_sec);
    end
    bus.btn_start = 1'b1;
    cyc();
    tests_run++;
    if (bus.state !== 3'd0 || bus.tmr_load !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_zero_preset: got state=%0d load=%0b, want 0 0", bus.state, bus.tmr_load);
    end
  endtask

  task automatic test_stop_paths();
    add_sec(5);
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_stop = 1'b1;
    cyc();
    tests_run++;
    if (bus.state !== 3'd3 || bus.magnetron !== 1'b0 || bus.lamp !== 1'b0) begin
      tests_failed++;
      $display("FAIL cook_stop_pause: got state=%0d mag=%0b lamp=%0b, want 3 0 0", bus.state, bus.magnetron, bus.lamp);
    end
    bus.btn_stop = 1'b1;
    cyc();
    tests_run++;
    if ({bus.state, bus.tmr_load, bus.tmr_min, bus.tmr_sec} !== {3'd0, 1'b1, 12'd0}) begin
      tests_failed++;
      $display("FAIL pause_stop_load: got state=%0d load=%0b %0d:%0d, want 0 1 0:0",
               bus.state, bus.tmr_load, bus.tmr_min, bus.tmr_sec);
    end
    add_min(2);
    bus.btn_start = 1'b1;
    cyc();
    bus.tmr_end  = 1'b1;
    bus.btn_stop = 1'b1;
    cyc();
    tests_run++;
    if (bus.state !== 3'd4 || bus.beep !== 1'b1) begin
      tests_failed++;
      $display("FAIL end_beats_stop: got state=%0d beep=%0b, want 4 1", bus.state, bus.beep);
    end
    bus.btn_stop = 1'b1;
    cyc();
    tests_run++;
    if ({bus.state, bus.beep, bus.tmr_min} !== {3'd0, 1'b0, 6'd0}) begin
      tests_failed++;
      $display("FAIL done_early_stop: got state=%0d beep=%0b min=%0d, want 0 0 0", bus.state, bus.beep, bus.tmr_min);
    end
  endtask

  task automatic test_reset_mid_cook();
    add_sec(10);
    bus.btn_start = 1'b1;
    cyc();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.state, bus.magnetron, bus.tmr_run, bus.lamp, bus.tmr_sec} !== {3'd0, 3'b000, 6'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_cook: got state=%0d mag=%0b run=%0b lamp=%0b sec=%0d, want 0 0 0 0 0",
               bus.state, bus.magnetron, bus.tmr_run, bus.lamp, bus.tmr_sec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

`ifdef POWER_LEVEL_EN
  task automatic test_power();
    logic [7:0] pattern;
    pattern = 8'b1100_1100;
    bus.power_sel = 2'b10;
    add_sec(20);
    bus.btn_start = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      cyc();
      tests_run++;
      if (bus.magnetron !== pattern[7-i]) begin
        tests_failed++;
        $display("FAIL power_window_%0d: got mag=%0b, want %0b", i, bus.magnetron, pattern[7-i]);
      end
      bus.tick_1hz = 1'b1;
      cyc();
    end
    bus.btn_stop = 1'b1;
    cyc();
    bus.btn_stop = 1'b1;
    cyc();
  endtask
`endif

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    bus.tick_1hz    = 1'b0;
    bus.btn_start   = 1'b0;
    bus.btn_stop    = 1'b0;
    bus.btn_add_min = 1'b0;
    bus.btn_add_sec = 1'b0;
    bus.door_open   = 1'b0;
    bus.tmr_end     = 1'b0;
`ifdef POWER_LEVEL_EN
    bus.power_sel   = 2'b00;
`endif
    test_reset();
    test_set_and_cook();
    test_pause_resume();
    test_done();
    test_carry_saturate();
    test_start_ignored();
    test_stop_paths();
    test_reset_mid_cook();
`ifdef POWER_LEVEL_EN
    test_power();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
